// File: rtl/sdram_cmd_responder.sv
// sdram_cmd_responder: device-side decoder and protocol checker for the SDRAM command bus.
// Latches the mode register, tracks per-bank open/idle state and the tRP/tMRD/tRCD
// spacing, and reports violations as single-cycle pulses plus a sticky accumulator.
module sdram_cmd_responder #(
    parameter int unsigned T_RP  = 2,  // all timing parameters must be >= 1
    parameter int unsigned T_MRD = 2,
    parameter int unsigned T_RCD = 2
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic [3:0]  i_sdram_cmd,
    input  logic [1:0]  i_sdram_ba,
    input  logic [11:0] i_sdram_addr,
    input  logic        i_err_clr,
    output logic [11:0] o_mode_reg,
    output logic        o_mode_valid,
    output logic [3:0]  o_burst_len,
    output logic [1:0]  o_cas_lat,
    output logic [3:0]  o_bank_open,
    output logic        o_rd_pulse,
    output logic        o_wr_pulse,
    output logic [4:0]  o_err_pulse,
    output logic [4:0]  o_err_sticky
);

    localparam int unsigned CW = 8;

    // A timer loaded with T-1 at edge t reads zero (expired) from edge t+T onwards.
    localparam logic [CW-1:0] RpLoad  = CW'(T_RP - 1);
    localparam logic [CW-1:0] MrdLoad = CW'(T_MRD - 1);
    localparam logic [CW-1:0] RcdLoad = CW'(T_RCD - 1);

    // {ras_n,cas_n,we_n} with cs_n low
    localparam logic [2:0] CmdLmr = 3'b000;
    localparam logic [2:0] CmdRef = 3'b001;
    localparam logic [2:0] CmdPre = 3'b010;
    localparam logic [2:0] CmdAct = 3'b011;
    localparam logic [2:0] CmdWr  = 3'b100;
    localparam logic [2:0] CmdRd  = 3'b101;
    localparam logic [2:0] CmdNop = 3'b111;

    // Error bit positions
    localparam int unsigned ErrTrp     = 0;
    localparam int unsigned ErrTmrd    = 1;
    localparam int unsigned ErrTrcd    = 2;
    localparam int unsigned ErrIllegal = 3;
    localparam int unsigned ErrNomode  = 4;

    typedef enum logic [1:0] {
        ModeUnset,
        ModeMrdWait,
        ModeSet
    } mode_state_e;

    mode_state_e r_mode_state, w_mode_state_d;

    logic [11:0]   r_mode_reg,   w_mode_reg_d;
    logic [3:0]    r_burst_len,  w_burst_len_d;
    logic [1:0]    r_cas_lat,    w_cas_lat_d;
    logic [3:0]    r_bank_open,  w_bank_open_d;
    logic          r_rd_pulse,   w_rd_pulse_d;
    logic          r_wr_pulse,   w_wr_pulse_d;
    logic [4:0]    r_err_pulse,  w_err_d;
    logic [4:0]    r_err_sticky, w_err_sticky_d;
    logic [CW-1:0] r_mrd,        w_mrd_d;
    logic [CW-1:0] r_trp  [4];
    logic [CW-1:0] w_trp_d  [4];
    logic [CW-1:0] r_trcd [4];
    logic [CW-1:0] w_trcd_d [4];

    logic       w_sel;
    logic       w_lmr;
    logic       w_active;
    logic       w_any_trp;
    logic       w_mode_valid;
    logic       w_bl_ok;
    logic       w_cl_ok;
    logic [3:0] w_bl_val;
    logic [1:0] w_cl_val;

    assign w_sel        = ~i_sdram_cmd[3];
    assign w_lmr        = w_sel && (i_sdram_cmd[2:0] == CmdLmr);
    assign w_active     = w_sel && (i_sdram_cmd[2:0] != CmdNop);
    assign w_mode_valid = (r_mode_state != ModeUnset);

    // Decode burst length and CAS latency fields of the mode word on the bus
    always_comb begin
        w_bl_ok  = 1'b1;
        w_bl_val = 4'd0;
        w_cl_ok  = 1'b1;
        w_cl_val = 2'd0;
        case (i_sdram_addr[2:0])
            3'b000:  w_bl_val = 4'd1;
            3'b001:  w_bl_val = 4'd2;
            3'b010:  w_bl_val = 4'd4;
            3'b011:  w_bl_val = 4'd8;
            3'b111:  w_bl_val = 4'd0;  // full page
            default: w_bl_ok  = 1'b0;
        endcase
        case (i_sdram_addr[6:4])
            3'b010:  w_cl_val = 2'd2;
            3'b011:  w_cl_val = 2'd3;
            default: w_cl_ok  = 1'b0;
        endcase
    end

    // Mode FSM next state and tMRD timer
    always_comb begin
        w_mode_state_d = r_mode_state;
        w_mrd_d        = (r_mrd != '0) ? r_mrd - 1'b1 : '0;
        if (w_lmr) begin
            w_mrd_d = MrdLoad;
        end
        case (r_mode_state)
            ModeUnset:   if (w_lmr) w_mode_state_d = ModeMrdWait;
            ModeMrdWait: if (!w_lmr && w_mrd_d == '0) w_mode_state_d = ModeSet;
            ModeSet:     if (w_lmr) w_mode_state_d = ModeMrdWait;
            default:     w_mode_state_d = ModeUnset;
        endcase
    end

    // Command decode: bank state, spacing timers, pulses and error flags
    always_comb begin
        w_mode_reg_d  = r_mode_reg;
        w_burst_len_d = r_burst_len;
        w_cas_lat_d   = r_cas_lat;
        w_bank_open_d = r_bank_open;
        w_rd_pulse_d  = 1'b0;
        w_wr_pulse_d  = 1'b0;
        w_err_d       = '0;
        w_any_trp     = 1'b0;
        for (int b = 0; b < 4; b++) begin
            w_trp_d[b]  = (r_trp[b]  != '0) ? r_trp[b]  - 1'b1 : '0;
            w_trcd_d[b] = (r_trcd[b] != '0) ? r_trcd[b] - 1'b1 : '0;
            w_any_trp   = w_any_trp | (r_trp[b] != '0);
        end

        w_err_d[ErrTmrd] = w_active && (r_mrd != '0);

        if (w_sel) begin
            case (i_sdram_cmd[2:0])
                CmdLmr: begin
                    w_err_d[ErrTrp]     = w_any_trp;
                    w_err_d[ErrIllegal] = (|r_bank_open) | ~w_bl_ok | ~w_cl_ok;
                    w_mode_reg_d        = i_sdram_addr;
                    // A reserved code in either field leaves both decodes untouched
                    if (w_bl_ok && w_cl_ok) begin
                        w_burst_len_d = w_bl_val;
                        w_cas_lat_d   = w_cl_val;
                    end
                end
                CmdRef: begin
                    w_err_d[ErrTrp]     = w_any_trp;
                    w_err_d[ErrIllegal] = |r_bank_open;
                    w_err_d[ErrNomode]  = ~w_mode_valid;
                end
                CmdPre: begin
                    if (i_sdram_addr[10]) begin
                        w_bank_open_d = '0;
                        for (int b = 0; b < 4; b++) begin
                            w_trp_d[b] = RpLoad;
                        end
                    end else begin
                        w_bank_open_d[i_sdram_ba] = 1'b0;
                        w_trp_d[i_sdram_ba]       = RpLoad;
                    end
                end
                CmdAct: begin
                    w_err_d[ErrTrp]           = (r_trp[i_sdram_ba] != '0);
                    w_err_d[ErrIllegal]       = r_bank_open[i_sdram_ba];
                    w_err_d[ErrNomode]        = ~w_mode_valid;
                    w_bank_open_d[i_sdram_ba] = 1'b1;
                    w_trcd_d[i_sdram_ba]      = RcdLoad;
                end
                CmdWr, CmdRd: begin
                    w_err_d[ErrTrcd]    = (r_trcd[i_sdram_ba] != '0);
                    w_err_d[ErrIllegal] = ~r_bank_open[i_sdram_ba];
                    w_err_d[ErrNomode]  = ~w_mode_valid;
                    w_rd_pulse_d        = i_sdram_cmd[0];
                    w_wr_pulse_d        = ~i_sdram_cmd[0];
                end
                default: ;  // BST and NOP leave bank and mode state alone
            endcase
        end

        // Clear and a fresh error on the same edge keep only the fresh bits
        w_err_sticky_d = i_err_clr ? w_err_d : (r_err_sticky | w_err_d);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_mode_state <= ModeUnset;
            r_mode_reg   <= '0;
            r_burst_len  <= '0;
            r_cas_lat    <= '0;
            r_bank_open  <= '0;
            r_rd_pulse   <= 1'b0;
            r_wr_pulse   <= 1'b0;
            r_err_pulse  <= '0;
            r_err_sticky <= '0;
            r_mrd        <= '0;
            for (int b = 0; b < 4; b++) begin
                r_trp[b]  <= '0;
                r_trcd[b] <= '0;
            end
        end else begin
            r_mode_state <= w_mode_state_d;
            r_mode_reg   <= w_mode_reg_d;
            r_burst_len  <= w_burst_len_d;
            r_cas_lat    <= w_cas_lat_d;
            r_bank_open  <= w_bank_open_d;
            r_rd_pulse   <= w_rd_pulse_d;
            r_wr_pulse   <= w_wr_pulse_d;
            r_err_pulse  <= w_err_d;
            r_err_sticky <= w_err_sticky_d;
            r_mrd        <= w_mrd_d;
            for (int b = 0; b < 4; b++) begin
                r_trp[b]  <= w_trp_d[b];
                r_trcd[b] <= w_trcd_d[b];
            end
        end
    end

    assign o_mode_reg   = r_mode_reg;
    assign o_mode_valid = w_mode_valid;
    assign o_burst_len  = r_burst_len;
    assign o_cas_lat    = r_cas_lat;
    assign o_bank_open  = r_bank_open;
    assign o_rd_pulse   = r_rd_pulse;
    assign o_wr_pulse   = r_wr_pulse;
    assign o_err_pulse  = r_err_pulse;
    assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// tb_sdram_cmd_responder: scoreboard bench. The driver applies one command per cycle and
// pushes the response predicted by an edge-indexed reference model; a monitor pops and
// compares after every rising edge.
module tb_sdram_cmd_responder;

    localparam int T_RP  = 2;
    localparam int T_MRD = 2;
    localparam int T_RCD = 2;
    localparam int Never = -1000;

    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] BST = 4'b0110;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] DES = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cmd = NOP;
    logic [1:0]  ba = '0;
    logic [11:0] addr = '0;
    logic        clr = 1'b0;
    logic [11:0] mode_reg;
    logic        mode_valid;
    logic [3:0]  burst_len;
    logic [1:0]  cas_lat;
    logic [3:0]  bank_open;
    logic        rd_pulse;
    logic        wr_pulse;
    logic [4:0]  err_pulse;
    logic [4:0]  err_sticky;

    always #5 clk = ~clk;

    sdram_cmd_responder #(
        .T_RP (T_RP),
        .T_MRD(T_MRD),
        .T_RCD(T_RCD)
    ) dut (
        .i_sys_clk   (clk),
        .i_sys_rst   (rst),
        .i_sdram_cmd (cmd),
        .i_sdram_ba  (ba),
        .i_sdram_addr(addr),
        .i_err_clr   (clr),
        .o_mode_reg  (mode_reg),
        .o_mode_valid(mode_valid),
        .o_burst_len (burst_len),
        .o_cas_lat   (cas_lat),
        .o_bank_open (bank_open),
        .o_rd_pulse  (rd_pulse),
        .o_wr_pulse  (wr_pulse),
        .o_err_pulse (err_pulse),
        .o_err_sticky(err_sticky)
    );

    typedef struct {
        int          id;
        logic [11:0] mode_reg;
        logic        mode_valid;
        logic [3:0]  bl;
        logic [1:0]  cl;
        logic [3:0]  open;
        logic        rd;
        logic        wr;
        logic [4:0]  err;
        logic [4:0]  sticky;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: remembers the edge index of the last PRE/ACT per bank and last LMR.
    int          edge_n = 0;
    int          last_pre[4];
    int          last_act[4];
    int          last_lmr;
    bit          m_mv;
    logic [11:0] m_mode;
    logic [3:0]  m_bl;
    logic [1:0]  m_cl;
    logic [3:0]  m_open;
    logic [4:0]  m_sticky;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            last_pre[b] = Never;
            last_act[b] = Never;
        end
        last_lmr = Never;
        m_mv     = 1'b0;
        m_mode   = '0;
        m_bl     = '0;
        m_cl     = '0;
        m_open   = '0;
        m_sticky = '0;
    endtask

    // Predict outputs after the edge that samples this command
    task automatic model(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                         input logic cl_in, input logic rs, output exp_t e);
        logic [4:0] err;
        logic       rdp;
        logic       wrp;
        bit         any_rp;
        int         blv;
        int         clv;
        err    = '0;
        rdp    = 1'b0;
        wrp    = 1'b0;
        any_rp = 0;
        if (rs) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (edge_n - last_pre[k] < T_RP) any_rp = 1;
            end
            if (c[3] == 1'b0 && c != NOP && edge_n - last_lmr < T_MRD) err[1] = 1'b1;
            case (c)
                LMR: begin
                    if (any_rp) err[0] = 1'b1;
                    if (m_open != 0) err[3] = 1'b1;
                    case (a[2:0])
                        3'd0: blv = 1;
                        3'd1: blv = 2;
                        3'd2: blv = 4;
                        3'd3: blv = 8;
                        3'd7: blv = 0;
                        default: blv = -1;
                    endcase
                    clv = (a[6:4] == 3'd2) ? 2 : (a[6:4] == 3'd3) ? 3 : -1;
                    if (blv < 0 || clv < 0) begin
                        err[3] = 1'b1;
                    end else begin
                        m_bl = 4'(blv);
                        m_cl = 2'(clv);
                    end
                    m_mode   = a;
                    m_mv     = 1'b1;
                    last_lmr = edge_n;
                end
                REF: begin
                    if (any_rp) err[0] = 1'b1;
                    if (m_open != 0) err[3] = 1'b1;
                    if (!m_mv) err[4] = 1'b1;
                end
                PRE: begin
                    for (int k = 0; k < 4; k++) begin
                        if (a[10] || k == int'(b)) begin
                            m_open[k]   = 1'b0;
                            last_pre[k] = edge_n;
                        end
                    end
                end
                ACT: begin
                    if (edge_n - last_pre[b] < T_RP) err[0] = 1'b1;
                    if (m_open[b]) err[3] = 1'b1;
                    if (!m_mv) err[4] = 1'b1;
                    m_open[b]   = 1'b1;
                    last_act[b] = edge_n;
                end
                RD, WR: begin
                    if (edge_n - last_act[b] < T_RCD) err[2] = 1'b1;
                    if (!m_open[b]) err[3] = 1'b1;
                    if (!m_mv) err[4] = 1'b1;
                    if (c == RD) rdp = 1'b1;
                    else wrp = 1'b1;
                end
                default: ;
            endcase
            m_sticky = cl_in ? err : (m_sticky | err);
        end
        e.id         = edge_n;
        e.mode_reg   = m_mode;
        e.mode_valid = m_mv;
        e.bl         = m_bl;
        e.cl         = m_cl;
        e.open       = m_open;
        e.rd         = rdp;
        e.wr         = wrp;
        e.err        = err;
        e.sticky     = m_sticky;
        edge_n++;
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] b = 2'd0,
                        input logic [11:0] a = 12'd0, input logic cl_in = 1'b0,
                        input logic rs = 1'b0);
        exp_t e;
        @(negedge clk);
        cmd  = c;
        ba   = b;
        addr = a;
        clr  = cl_in;
        rst  = rs;
        model(c, b, a, cl_in, rs, e);
        exp_q.push_back(e);
    endtask

    // Monitor: every edge produces a registered response; compare it to the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mode_reg",   e.id, 32'(mode_reg),   32'(e.mode_reg));
                check("mode_valid", e.id, 32'(mode_valid), 32'(e.mode_valid));
                check("burst_len",  e.id, 32'(burst_len),  32'(e.bl));
                check("cas_lat",    e.id, 32'(cas_lat),    32'(e.cl));
                check("bank_open",  e.id, 32'(bank_open),  32'(e.open));
                check("rd_pulse",   e.id, 32'(rd_pulse),   32'(e.rd));
                check("wr_pulse",   e.id, 32'(wr_pulse),   32'(e.wr));
                check("err_pulse",  e.id, 32'(err_pulse),  32'(e.err));
                check("err_sticky", e.id, 32'(err_sticky), 32'(e.sticky));
            end
        end
    end

    initial begin
        logic [11:0] a;
        logic [3:0]  c;
        int          r;
        int          k;
        model_reset();

        // Reset, settle, program mode, open bank 0
        step(NOP, 0, 0, 0, 1);
        repeat (3) step(NOP);
        step(LMR, 0, 12'h032);
        step(NOP);
        step(ACT, 0);
        // LMR immediately followed by ACT violates tMRD; then clear the sticky flags
        step(PRE, 0, 12'h400);
        step(NOP);
        step(LMR, 0, 12'h032);
        step(ACT, 1);
        step(NOP, 0, 0, 1);
        // PRE all then ACT one edge later (tRP), then two edges later (legal)
        step(PRE, 0, 12'h400);
        step(ACT, 2);
        step(PRE, 0, 12'h400);
        step(NOP);
        step(ACT, 2);
        // tRCD, read of an idle bank, ACT to an open bank
        step(ACT, 3);
        step(RD, 3);
        step(RD, 0);
        step(ACT, 3);
        step(WR, 3);
        step(BST);
        // No mode after reset, then reserved burst length
        step(NOP, 0, 0, 0, 1);
        step(ACT, 0);
        step(NOP);
        step(LMR, 0, 12'h034);
        step(REF);
        // Init sequence interrupted by reset during the mode wait, then replayed cleanly
        step(NOP, 0, 0, 0, 1);
        step(PRE, 0, 12'h400);
        repeat (3) step(NOP);
        step(LMR, 0, 12'h032);
        step(NOP, 0, 0, 0, 1);
        step(PRE, 0, 12'h400);
        repeat (3) step(DES);
        step(LMR, 0, 12'h023);
        repeat (3) step(NOP);
        step(REF);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            a = 12'($urandom);
            if      (r < 25) c = NOP;
            else if (r < 30) c = DES | 4'($urandom_range(0, 7));
            else if (r < 35) c = LMR;
            else if (r < 42) c = REF;
            else if (r < 57) c = PRE;
            else if (r < 72) c = ACT;
            else if (r < 82) c = RD;
            else if (r < 92) c = WR;
            else             c = BST;
            if (c == LMR && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, 4);
                a[2:0] = (k == 4) ? 3'd7 : 3'(k);
                a[6:4] = 3'($urandom_range(2, 3));
            end
            step(c, 2'($urandom), a, ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 199) == 0));
        end
        step(NOP);

        @(posedge clk);
        #2;
        check("queue_drain", edge_n, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
